// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types, constants and target helper for the fetch unit
package fetch_unit_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FSM_BOOT = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_HALT = 2'd2
  } fetch_state_e;

  // Redirect base selector codes
  localparam logic REDIR_PCREL = 1'b0;
  localparam logic REDIR_JALR  = 1'b1;

  // Sequential fetch stride in bytes
  localparam logic [31:0] PC_STEP = 32'd4;

  // Redirect target: PC-relative adds to the redirecting PC, JALR adds to rs1
  // and clears bit 0. Plain 32-bit wrap-around arithmetic.
  function automatic logic [31:0] redirect_target(
    input logic        sel,
    input logic [31:0] pc,
    input logic [31:0] rs1,
    input logic [31:0] imm
  );
    logic [31:0] sum;
    sum = ((sel == REDIR_JALR) ? rs1 : pc) + imm;
    if (sel == REDIR_JALR) sum[0] = 1'b0;
    return sum;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer with flush and occupancy count
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only accepted when the head leaves the same cycle
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Pointer and occupancy bookkeeping; flush empties the buffer and wins over push/pop
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch front end with PC, request credits and redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  input  logic        redirect_valid,
  input  logic        redirect_sel,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_rs1,
  input  logic [31:0] redirect_imm,
  output logic        fetch_misaligned,
  output logic [31:0] misaligned_addr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = CW + 1;

  fetch_state_e state;
  logic [31:0]  pc_q;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [IW-1:0] inflight;

  logic         req_fire;
  logic         rsp_fire;
  logic         rsp_keep;
  logic [31:0]  redir_target;

  // Addresses of requests still in flight, in issue order, so each returning
  // word can be tagged with its PC (dropped responses consume their entry too)
  logic [31:0]  shadow [FIFO_DEPTH];
  logic [AW-1:0] sh_wr;
  logic [AW-1:0] sh_rd;

  logic [63:0]  fifo_head;
  logic         fifo_empty;

  // Credits: in-flight requests plus buffered words never exceed the buffer size
  assign inflight        = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid  = (state == FSM_RUN) && (inflight < IW'(FIFO_DEPTH));
  assign imem_req_addr   = pc_q;
  assign req_fire        = imem_req_valid && imem_req_ready;

  // Responses during BOOT belong to a pre-reset world and are ignored outright
  assign rsp_fire        = imem_rsp_valid && (state != FSM_BOOT);
  // A response in the redirect cycle is already stale, so it is never buffered
  assign rsp_keep        = rsp_fire && (drop_cnt == '0) && !redirect_valid;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_fire);

  assign redir_target    = redirect_target(redirect_sel, redirect_pc, redirect_rs1, redirect_imm);

  assign inst_valid      = !fifo_empty;
  assign inst            = fifo_head[31:0];
  assign inst_pc         = fifo_head[63:32];
  assign inst_pc4        = fifo_head[63:32] + PC_STEP;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({shadow[sh_rd], imem_rsp_data}),
    .pop       (inst_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sequencer: BOOT for one cycle, RUN fetches, HALT parks on a misaligned target
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= FSM_BOOT;
      pc_q             <= {RESET_PC[31:2], 2'b00};
      fetch_misaligned <= 1'b0;
      misaligned_addr  <= '0;
    end else begin
      fetch_misaligned <= 1'b0;
      if (redirect_valid) begin
        if (redir_target[1]) begin
          fetch_misaligned <= 1'b1;
          misaligned_addr  <= redir_target;
          state            <= FSM_HALT;
        end else begin
          pc_q  <= {redir_target[31:2], 2'b00};
          state <= FSM_RUN;
        end
      end else begin
        if (req_fire) pc_q <= pc_q + PC_STEP;
        if (state == FSM_BOOT) state <= FSM_RUN;
      end
    end
  end

  // Outstanding/drop accounting; a redirect marks every request still in flight as stale
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
      sh_wr       <= '0;
      sh_rd       <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        drop_cnt <= outstanding_nxt;
      end else if (rsp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (req_fire) sh_wr <= sh_wr + AW'(1);
      if (rsp_fire) sh_rd <= sh_rd + AW'(1);
    end
  end

  // Record each accepted request address for PC tagging on return
  always_ff @(posedge clk) begin
    if (rst_n && req_fire) shadow[sh_wr] <= pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with random memory and redirects
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        redirect_valid;
  logic        redirect_sel;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_rs1;
  logic [31:0] redirect_imm;
  logic        fetch_misaligned;
  logic [31:0] misaligned_addr;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .inst_pc4         (inst_pc4),
    .redirect_valid   (redirect_valid),
    .redirect_sel     (redirect_sel),
    .redirect_pc      (redirect_pc),
    .redirect_rs1     (redirect_rs1),
    .redirect_imm     (redirect_imm),
    .fetch_misaligned (fetch_misaligned),
    .misaligned_addr  (misaligned_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          id;
    int          ready;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          id;
  } exp_t;

  mreq_t mem_q[$];
  exp_t  exp_q[$];
  int    resp_cyc[int];

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          next_id = 0;
  logic [31:0] model_pc;
  logic        halted;
  logic        boot;
  logic        pulse_exp;
  logic [31:0] mis_exp;
  logic        after_rst;
  logic        exp_iv;

  logic        r_rst, r_rv, r_sel, r_rq, r_ir;
  logic [31:0] r_pc, r_rs1, r_imm;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Words returned by memory before this cycle and not yet delivered or flushed
  function automatic int buffered();
    int n = 0;
    foreach (exp_q[i]) begin
      if (resp_cyc.exists(exp_q[i].id)) begin
        if (resp_cyc[exp_q[i].id] < cyc) n++;
      end
    end
    return n;
  endfunction

  // One clock of stimulus: memory model, decode handshake, redirect, reset
  task automatic step(input logic do_rst, input logic rv, input logic sel,
                      input logic [31:0] rpc, input logic [31:0] rrs1, input logic [31:0] rimm,
                      input logic rq_rdy, input logic i_rdy, input int lat);
    logic        rv_eff;
    logic        exp_rv;
    logic [31:0] tgt;
    int          inflight;
    @(negedge clk);
    cyc++;
    imem_req_ready = rq_rdy;
    inst_ready     = i_rdy;
    if (do_rst) begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      mem_q.delete();
      exp_q.delete();
      halted    = 1'b0;
      boot      = 1'b1;
      model_pc  = RESET_PC;
      pulse_exp = 1'b0;
      mis_exp   = '0;
      after_rst = 1'b1;
      return;
    end
    rst_n = 1'b1;
    if (after_rst) begin
      chk("reset_outputs", misaligned_addr | {29'd0, imem_req_valid, inst_valid, fetch_misaligned}, 32'd0);
      after_rst = 1'b0;
    end
    inflight = mem_q.size() + buffered();
    exp_rv   = !boot && !halted && (inflight < FIFO_DEPTH);
    chk("req_valid", imem_req_valid, exp_rv);
    chk("fetch_misaligned", fetch_misaligned, pulse_exp);
    chk("misaligned_addr", misaligned_addr, mis_exp);
    pulse_exp = 1'b0;
    rv_eff = rv && !boot;

    if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      resp_cyc[mem_q[0].id] = cyc;
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end

    if (imem_req_valid && rq_rdy) begin
      if (exp_rv) chk("req_addr", imem_req_addr, model_pc);
      mem_q.push_back('{imem_req_addr, next_id, cyc + 1 + lat});
      if (!rv_eff && exp_rv) begin
        exp_q.push_back('{model_pc, mem_word(model_pc), next_id});
        model_pc = model_pc + 32'd4;
      end
      next_id++;
    end

    redirect_valid = rv_eff;
    redirect_sel   = sel;
    redirect_pc    = rpc;
    redirect_rs1   = rrs1;
    redirect_imm   = rimm;
    if (rv_eff) begin
      tgt = (sel ? rrs1 : rpc) + rimm;
      if (sel) tgt[0] = 1'b0;
      if (tgt[1]) begin
        halted    = 1'b1;
        pulse_exp = 1'b1;
        mis_exp   = tgt;
      end else begin
        halted   = 1'b0;
        model_pc = tgt;
      end
    end
    boot = 1'b0;
  endtask

  // Monitor: checks delivery against the scoreboard and applies flushes
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      exp_iv = 1'b0;
      if (exp_q.size() > 0) begin
        if (resp_cyc.exists(exp_q[0].id)) exp_iv = (resp_cyc[exp_q[0].id] < cyc);
      end
      chk("inst_valid", inst_valid, exp_iv);
      if (inst_valid && exp_iv && inst_ready && !redirect_valid) begin
        chk("inst", inst, exp_q[0].data);
        chk("inst_pc", inst_pc, exp_q[0].pc);
        chk("inst_pc4", inst_pc4, exp_q[0].pc + 32'd4);
        void'(exp_q.pop_front());
      end
      if (redirect_valid) exp_q.delete();
      chk("fifo_bound", 32'(dut.fifo_count <= FIFO_DEPTH), 32'd1);
    end
  end

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_sel = 1'b0;
    redirect_pc = '0; redirect_rs1 = '0; redirect_imm = '0;
    model_pc = RESET_PC; halted = 1'b0; boot = 1'b1; pulse_exp = 1'b0;
    mis_exp = '0; after_rst = 1'b0; exp_iv = 1'b0;

    repeat (2) step(1, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (20) step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 1, 4);
    step(0, 1, 0, 32'h100, 0, 32'hFFFF_FFF8, 1, 1, 4);
    repeat (15) step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 1, 0, 32'h2001, 32'h0, 1, 1, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 1, 0, 32'h1000, 32'h2, 1, 1, 0);
    repeat (8) step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 32'h3000, 0, 32'h0, 1, 1, 0);
    repeat (12) step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 1, 3);
    step(1, 0, 0, 0, 0, 0, 1, 1, 0);
    repeat (15) step(0, 0, 0, 0, 0, 0, 1, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 399) == 0);
      r_rv  = ($urandom_range(0, 19) == 0);
      r_sel = $urandom_range(0, 1);
      r_pc  = $urandom & 32'h0003_FFFC;
      r_rs1 = $urandom & 32'h0003_FFFF;
      if ($urandom_range(0, 3) == 0) r_imm = 32'($urandom_range(0, 63)) * 32'd2 - 32'd64;
      else                           r_imm = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
      r_rq  = ($urandom_range(0, 3) != 0);
      r_ir  = ($urandom_range(0, 3) != 0);
      step(r_rst, r_rv, r_sel, r_pc, r_rs1, r_imm, r_rq, r_ir, $urandom_range(0, 3));
    end

    repeat (40) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("drain_scoreboard", exp_q.size(), 0);
    chk("drain_memory", mem_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
